// File: rtl/pcie_dn_wrr_arbit.sv
// Packet-level weighted round-robin arbiter sharing the PCIe download TX path
// between P_CH_NUM DMA requesters, with per-grant credits and an idle watchdog.
`timescale 1ns/1ps
module pcie_dn_wrr_arbit #(
    parameter int P_CH_NUM = 4,
    parameter int P_DW     = 64,
    parameter int P_WGT_W  = 4,
    parameter int P_TMO_W  = 16
) (
    input  logic                        PCIE_CLK,
    input  logic                        PCIE_RST,
    input  logic [P_CH_NUM*P_WGT_W-1:0] CFG_WEIGHT,
    input  logic [P_TMO_W-1:0]          CFG_TMO,
    input  logic [P_CH_NUM-1:0]         CH_REQ,
    output logic [P_CH_NUM-1:0]         CH_GNT,
    output logic [P_CH_NUM-1:0]         CH_ACK,
    input  logic [P_CH_NUM-1:0]         CH_DVLD,
    input  logic [P_CH_NUM-1:0]         CH_SOP,
    input  logic [P_CH_NUM-1:0]         CH_EOP,
    input  logic [P_CH_NUM-1:0]         CH_END,
    input  logic [P_CH_NUM*P_DW-1:0]    CH_DATA,
    input  logic [P_CH_NUM*2-1:0]       CH_MASK,
    output logic                        TX_REQ,
    input  logic                        TX_ACK,
    output logic                        TX_DVLD,
    output logic                        TX_SOP,
    output logic                        TX_EOP,
    output logic                        TX_END,
    output logic [P_DW-1:0]             TX_DATA,
    output logic [1:0]                  TX_MASK,
    output logic                        STS_TMO,
    output logic [2:0]                  STS_CH
);

    localparam int IDX_W = (P_CH_NUM > 1) ? $clog2(P_CH_NUM) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ARB  = 2'd1;
    localparam logic [1:0] S_TX   = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    logic [1:0]         state;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   owner;
    logic [IDX_W-1:0]   owner_nxt;
    logic [IDX_W-1:0]   win;
    logic [P_CH_NUM-1:0] win_oh;
    logic [P_WGT_W-1:0] win_wgt;
    logic [P_WGT_W-1:0] credit;
    logic [P_TMO_W-1:0] wdog;
    logic [P_TMO_W:0]   wdog_inc;
    logic               sel_dvld;
    logic               sel_sop;
    logic               sel_eop;
    logic               sel_end;
    logic               sel_req;
    logic [P_DW-1:0]    sel_data;
    logic [1:0]         sel_mask;
    logic               tmo_hit;

    function automatic logic [IDX_W-1:0] wrap_idx(input int v);
        return (v >= P_CH_NUM) ? IDX_W'(v - P_CH_NUM) : IDX_W'(v);
    endfunction

    // Walk downwards so the lowest offset from ptr overwrites earlier hits.
    always_comb begin
        win     = ptr;
        win_oh  = '0;
        win_wgt = '0;
        for (int i = P_CH_NUM - 1; i >= 0; i--) begin
            if (CH_REQ[wrap_idx(int'(ptr) + i)]) begin
                win = wrap_idx(int'(ptr) + i);
            end
        end
        for (int i = 0; i < P_CH_NUM; i++) begin
            win_oh[i] = (win == IDX_W'(i));
            if (win_oh[i]) begin
                win_wgt = CFG_WEIGHT[i*P_WGT_W +: P_WGT_W];
            end
        end
    end

    // CH_GNT is one-hot while a channel owns the path, so an AND-OR mux suffices.
    always_comb begin
        sel_dvld = 1'b0;
        sel_sop  = 1'b0;
        sel_eop  = 1'b0;
        sel_end  = 1'b0;
        sel_req  = 1'b0;
        sel_data = '0;
        sel_mask = '0;
        for (int i = 0; i < P_CH_NUM; i++) begin
            if (CH_GNT[i]) begin
                sel_dvld = sel_dvld | CH_DVLD[i];
                sel_sop  = sel_sop  | CH_SOP[i];
                sel_eop  = sel_eop  | CH_EOP[i];
                sel_end  = sel_end  | CH_END[i];
                sel_req  = sel_req  | CH_REQ[i];
                sel_data = sel_data | CH_DATA[i*P_DW +: P_DW];
                sel_mask = sel_mask | CH_MASK[i*2 +: 2];
            end
        end
    end

    assign wdog_inc  = {1'b0, wdog} + (P_TMO_W+1)'(1);
    assign tmo_hit   = (state == S_TX) && (CFG_TMO != '0) && !sel_dvld && !sel_end
                       && (wdog_inc >= {1'b0, CFG_TMO});
    assign owner_nxt = (owner == IDX_W'(P_CH_NUM - 1)) ? '0 : owner + IDX_W'(1);
    assign CH_ACK    = CH_GNT & {P_CH_NUM{TX_ACK}};
    assign STS_CH    = 3'(owner);

    always_ff @(posedge PCIE_CLK) begin
        if (PCIE_RST) begin
            state   <= S_IDLE;
            ptr     <= '0;
            owner   <= '0;
            credit  <= '0;
            wdog    <= '0;
            CH_GNT  <= '0;
            TX_REQ  <= 1'b0;
            TX_DVLD <= 1'b0;
            TX_SOP  <= 1'b0;
            TX_EOP  <= 1'b0;
            TX_END  <= 1'b0;
            TX_DATA <= '0;
            TX_MASK <= '0;
            STS_TMO <= 1'b0;
        end else begin
            TX_DVLD <= 1'b0;
            TX_SOP  <= 1'b0;
            TX_EOP  <= 1'b0;
            TX_END  <= 1'b0;
            TX_DATA <= '0;
            TX_MASK <= '0;
            STS_TMO <= 1'b0;
            case (state)
                S_IDLE: state <= S_ARB;
                S_ARB: begin
                    if (|CH_REQ) begin
                        CH_GNT <= win_oh;
                        owner  <= win;
                        credit <= (win_wgt == '0) ? P_WGT_W'(1) : win_wgt;
                        wdog   <= '0;
                        TX_REQ <= 1'b1;
                        state  <= S_TX;
                    end
                end
                S_TX: begin
                    // END takes priority over a coincident watchdog expiry.
                    if (sel_end) begin
                        credit <= credit - P_WGT_W'(1);
                        TX_END <= 1'b1;
                        TX_REQ <= 1'b0;
                        state  <= S_GAP;
                    end else if (tmo_hit) begin
                        credit  <= '0;
                        TX_END  <= 1'b1;
                        STS_TMO <= 1'b1;
                        TX_REQ  <= 1'b0;
                        state   <= S_GAP;
                    end else begin
                        TX_DVLD <= sel_dvld;
                        TX_SOP  <= sel_sop;
                        TX_EOP  <= sel_eop;
                        TX_DATA <= sel_data;
                        TX_MASK <= sel_mask;
                        if (CFG_TMO == '0 || sel_dvld) begin
                            wdog <= '0;
                        end else begin
                            wdog <= wdog_inc[P_TMO_W-1:0];
                        end
                    end
                end
                default: begin
                    if (credit != '0 && sel_req) begin
                        wdog   <= '0;
                        TX_REQ <= 1'b1;
                        state  <= S_TX;
                    end else begin
                        CH_GNT <= '0;
                        ptr    <= owner_nxt;
                        state  <= S_ARB;
                    end
                end
            endcase
        end
    end

endmodule
